// File: rtl/cache_stats_counter_if.sv
// Event, control and snapshot bundle between the cache controllers,
// the statistics counter and the display block.
interface cache_stats_counter_if #(
    parameter int CNT_W = 32
);
    logic             ins_read_ev;
    logic             ins_hit_ev;
    logic             ins_miss_ev;
    logic             data_read_ev;
    logic             data_write_ev;
    logic             data_hit_ev;
    logic             data_miss_ev;
    logic             clear;
    logic             print_req;
    logic             busy;
    logic             print;
    logic [CNT_W-1:0] ins_reads;
    logic [CNT_W-1:0] ins_hit;
    logic [CNT_W-1:0] ins_miss;
    logic [CNT_W-1:0] data_reads;
    logic [CNT_W-1:0] data_writes;
    logic [CNT_W-1:0] data_hit;
    logic [CNT_W-1:0] data_miss;
    logic             proto_err;

    modport master (
        output ins_read_ev, ins_hit_ev, ins_miss_ev,
        output data_read_ev, data_write_ev,
        output data_hit_ev, data_miss_ev,
        output clear, print_req,
        input  busy, print, proto_err,
        input  ins_reads, ins_hit, ins_miss,
        input  data_reads, data_writes, data_hit, data_miss
    );

    modport slave (
        input  ins_read_ev, ins_hit_ev, ins_miss_ev,
        input  data_read_ev, data_write_ev,
        input  data_hit_ev, data_miss_ev,
        input  clear, print_req,
        output busy, print, proto_err,
        output ins_reads, ins_hit, ins_miss,
        output data_reads, data_writes, data_hit, data_miss
    );
endinterface

// File: rtl/cache_stats_counter.sv
// Saturating cache event counters with a three-state snapshot/print
// sequencer feeding the statistics display block.
module cache_stats_counter #(
    parameter int CNT_W = 32
) (
    input logic                  clk,
    input logic                  reset_n,
    cache_stats_counter_if.slave bus
);
    localparam int N = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SNAP  = 2'd1,
        PRINT = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     ev;
    logic [CNT_W-1:0] live_q [N];
    logic [CNT_W-1:0] live_d [N];
    logic [CNT_W-1:0] snap_q [N];
    logic             perr_q, perr_d;

    // Index order: ins read/hit/miss, then data read/write/hit/miss.
    assign ev = {bus.data_miss_ev, bus.data_hit_ev,
                 bus.data_write_ev, bus.data_read_ev,
                 bus.ins_miss_ev, bus.ins_hit_ev,
                 bus.ins_read_ev};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.print_req) state_d = SNAP;
            SNAP:    state_d = PRINT;
            PRINT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            live_d[i] = live_q[i];
            if (bus.clear)
                live_d[i] = '0;
            else if (ev[i] && (live_q[i] != '1))
                live_d[i] = live_q[i] + CNT_W'(1);
        end
    end

    always_comb begin
        perr_d = perr_q;
        if (bus.clear)
            perr_d = 1'b0;
        else if ((bus.ins_hit_ev && bus.ins_miss_ev) ||
                 (bus.data_hit_ev && bus.data_miss_ev))
            perr_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            perr_q  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                live_q[i] <= '0;
                snap_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            perr_q  <= perr_d;
            for (int i = 0; i < N; i++) begin
                live_q[i] <= live_d[i];
                // Registered live values: a clear during SNAP is not seen.
                if (state_q == SNAP)
                    snap_q[i] <= live_q[i];
            end
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.print       = (state_q == PRINT);
    assign bus.proto_err   = perr_q;
    assign bus.ins_reads   = snap_q[0];
    assign bus.ins_hit     = snap_q[1];
    assign bus.ins_miss    = snap_q[2];
    assign bus.data_reads  = snap_q[3];
    assign bus.data_writes = snap_q[4];
    assign bus.data_hit    = snap_q[5];
    assign bus.data_miss   = snap_q[6];
endmodule

// File: tb/tb_cache_stats_counter.sv
// Directed table-driven bench for cache_stats_counter, with a
// 4-bit instance alongside for the saturation corner.
module tb_cache_stats_counter;
    localparam logic [6:0] IR = 7'b0000001;
    localparam logic [6:0] IH = 7'b0000010;
    localparam logic [6:0] IM = 7'b0000100;
    localparam logic [6:0] DR = 7'b0001000;
    localparam logic [6:0] DW = 7'b0010000;
    localparam logic [6:0] DH = 7'b0100000;
    localparam logic [6:0] DM = 7'b1000000;

    typedef logic [6:0][31:0] snap_t;

    typedef struct packed {
        logic [6:0] ev;
        logic       clr;
        logic       req;
        logic       busy;
        logic       prn;
        logic       perr;
        snap_t      snap;
    } vec_t;

    logic       clk;
    logic       reset_n;
    logic [6:0] ev_r;
    logic       clr_r;
    logic       req_r;
    int         checks;
    int         errors;
    vec_t       vq[$];
    logic [223:0] bsnap;

    cache_stats_counter_if #(.CNT_W(32)) bus ();
    cache_stats_counter_if #(.CNT_W(4))  sbus ();

    cache_stats_counter #(.CNT_W(32)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    cache_stats_counter #(.CNT_W(4)) u_small (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (sbus)
    );

    assign bus.ins_read_ev    = ev_r[0];
    assign bus.ins_hit_ev     = ev_r[1];
    assign bus.ins_miss_ev    = ev_r[2];
    assign bus.data_read_ev   = ev_r[3];
    assign bus.data_write_ev  = ev_r[4];
    assign bus.data_hit_ev    = ev_r[5];
    assign bus.data_miss_ev   = ev_r[6];
    assign bus.clear          = clr_r;
    assign bus.print_req      = req_r;
    assign sbus.ins_read_ev   = ev_r[0];
    assign sbus.ins_hit_ev    = ev_r[1];
    assign sbus.ins_miss_ev   = ev_r[2];
    assign sbus.data_read_ev  = ev_r[3];
    assign sbus.data_write_ev = ev_r[4];
    assign sbus.data_hit_ev   = ev_r[5];
    assign sbus.data_miss_ev  = ev_r[6];
    assign sbus.clear         = clr_r;
    assign sbus.print_req     = req_r;

    assign bsnap = {bus.data_miss, bus.data_hit, bus.data_writes,
                    bus.data_reads, bus.ins_miss, bus.ins_hit,
                    bus.ins_reads};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic snap_t mk(int ir, int ih, int im, int dr,
                                 int dw, int dh, int dm);
        snap_t s;
        s[0] = 32'(ir);
        s[1] = 32'(ih);
        s[2] = 32'(im);
        s[3] = 32'(dr);
        s[4] = 32'(dw);
        s[5] = 32'(dh);
        s[6] = 32'(dm);
        return s;
    endfunction

    function automatic vec_t row(logic [6:0] ev, logic clr, logic req,
                                 logic busy, logic prn, logic perr,
                                 snap_t snap);
        vec_t v;
        v.ev   = ev;
        v.clr  = clr;
        v.req  = req;
        v.busy = busy;
        v.prn  = prn;
        v.perr = perr;
        v.snap = snap;
        return v;
    endfunction

    task automatic chk(input string name, input logic [223:0] act,
                       input logic [223:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [6:0] ev, input logic clr,
                       input logic req);
        ev_r  = ev;
        clr_r = clr;
        req_r = req;
        @(posedge clk);
        #1;
    endtask

    initial begin
        snap_t s0, s1, s2, s3, s5, g1, g2, g3, g4, h;
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        ev_r    = '0;
        clr_r   = 1'b0;
        req_r   = 1'b0;

        s0 = mk(0, 0, 0, 0, 0, 0, 0);
        s1 = mk(3, 3, 0, 0, 0, 0, 0);
        s2 = mk(3, 3, 0, 0, 5, 0, 2);
        s3 = mk(3, 3, 0, 1, 5, 0, 2);
        s5 = mk(1, 0, 0, 0, 0, 0, 0);
        g1 = mk(1, 0, 0, 0, 0, 0, 0);
        g2 = mk(4, 0, 0, 0, 0, 0, 0);
        g3 = mk(7, 0, 0, 0, 0, 0, 0);
        g4 = mk(10, 0, 0, 0, 0, 0, 0);
        h  = mk(10, 1, 1, 0, 0, 0, 0);

        // ev, clear, req -> busy, print, proto_err, snapshot after edge
        repeat (3) vq.push_back(row(IR | IH, 0, 0, 0, 0, 0, s0));
        vq.push_back(row(0, 0, 1, 1, 0, 0, s0));
        vq.push_back(row(0, 0, 0, 1, 1, 0, s1));
        vq.push_back(row(0, 0, 0, 0, 0, 0, s1));
        repeat (3) vq.push_back(row(DW, 0, 0, 0, 0, 0, s1));
        vq.push_back(row(DW | DM, 0, 0, 0, 0, 0, s1));
        vq.push_back(row(DW | DM, 0, 1, 1, 0, 0, s1));
        vq.push_back(row(DR, 0, 0, 1, 1, 0, s2));
        vq.push_back(row(0, 0, 0, 0, 0, 0, s2));
        vq.push_back(row(0, 0, 1, 1, 0, 0, s2));
        vq.push_back(row(0, 0, 0, 1, 1, 0, s3));
        vq.push_back(row(0, 0, 0, 0, 0, 0, s3));
        vq.push_back(row(DH, 1, 0, 0, 0, 0, s3));
        vq.push_back(row(0, 0, 1, 1, 0, 0, s3));
        vq.push_back(row(0, 0, 0, 1, 1, 0, s0));
        vq.push_back(row(0, 0, 0, 0, 0, 0, s0));
        vq.push_back(row(IR, 0, 0, 0, 0, 0, s0));
        vq.push_back(row(0, 0, 1, 1, 0, 0, s0));
        vq.push_back(row(0, 1, 0, 1, 1, 0, s5));
        vq.push_back(row(0, 0, 0, 0, 0, 0, s5));
        vq.push_back(row(IR, 0, 1, 1, 0, 0, s5));
        vq.push_back(row(IR, 0, 1, 1, 1, 0, g1));
        vq.push_back(row(IR, 0, 1, 0, 0, 0, g1));
        vq.push_back(row(IR, 0, 1, 1, 0, 0, g1));
        vq.push_back(row(IR, 0, 1, 1, 1, 0, g2));
        vq.push_back(row(IR, 0, 1, 0, 0, 0, g2));
        vq.push_back(row(IR, 0, 1, 1, 0, 0, g2));
        vq.push_back(row(IR, 0, 1, 1, 1, 0, g3));
        vq.push_back(row(IR, 0, 1, 0, 0, 0, g3));
        vq.push_back(row(IR, 0, 1, 1, 0, 0, g3));
        vq.push_back(row(0, 0, 0, 1, 1, 0, g4));
        vq.push_back(row(0, 0, 0, 0, 0, 0, g4));
        vq.push_back(row(IH | IM, 0, 0, 0, 0, 1, g4));
        vq.push_back(row(0, 0, 1, 1, 0, 1, g4));
        vq.push_back(row(0, 0, 0, 1, 1, 1, h));
        vq.push_back(row(0, 0, 0, 0, 0, 1, h));
        vq.push_back(row(0, 1, 0, 0, 0, 0, h));
        vq.push_back(row(DH | DM, 0, 0, 0, 0, 1, h));
        vq.push_back(row(DH | DM, 1, 0, 0, 0, 0, h));
        vq.push_back(row(DR, 0, 0, 0, 0, 0, h));
        vq.push_back(row(DR, 1, 1, 1, 0, 0, h));
        vq.push_back(row(0, 0, 0, 1, 1, 0, s0));
        vq.push_back(row(0, 0, 0, 0, 0, 0, s0));

        repeat (2) @(posedge clk);
        #1;
        chk("reset ctl", 224'({bus.busy, bus.print, bus.proto_err}), '0);
        chk("reset snap", bsnap, '0);
        reset_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            cyc(vq[i].ev, vq[i].clr, vq[i].req);
            chk($sformatf("row%0d busy", i), 224'(bus.busy),
                224'(vq[i].busy));
            chk($sformatf("row%0d print", i), 224'(bus.print),
                224'(vq[i].prn));
            chk($sformatf("row%0d proto_err", i), 224'(bus.proto_err),
                224'(vq[i].perr));
            chk($sformatf("row%0d snap", i), bsnap, vq[i].snap);
        end

        // Saturation on the 4-bit instance, plain count on the 32-bit one.
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 14; i++) cyc(DR, 0, 0);
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        chk("sat print", 224'(sbus.print), 224'(1));
        chk("sat pre", 224'(sbus.data_reads), 224'(4'hE));
        cyc(0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(DR, 0, 0);
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        chk("sat small", 224'(sbus.data_reads), 224'(4'hF));
        chk("sat big", 224'(bus.data_reads), 224'(17));
        cyc(0, 0, 0);

        // Asynchronous reset while the print strobe is high.
        cyc(IH | IM, 0, 0);
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        chk("pre-rst print", 224'(bus.print), 224'(1));
        chk("pre-rst perr", 224'(bus.proto_err), 224'(1));
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst ctl", 224'({bus.busy, bus.print, bus.proto_err}), '0);
        chk("rst snap", bsnap, '0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc(0, 0, 0);
        chk("post-rst ctl", 224'({bus.busy, bus.print, bus.proto_err}),
            '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_stats_counter.md
# cache_stats_counter

Event accumulator and snapshot driver for the cache statistics path. Counts per-cycle hit/miss/read/write strobes from the instruction and data cache controllers. On a print request it freezes a consistent snapshot of all seven counters and drives the snapshot plus a one-cycle `print` strobe to the statistics display block. A clear command, the trace "clear" operation, zeroes the live counters.

## Interface
Parameters:
- CNT_W, 32, width of every counter and snapshot output

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- ins_read_ev  in  1  one instruction read this cycle
- ins_hit_ev  in  1  instruction cache hit this cycle
- ins_miss_ev  in  1  instruction cache miss this cycle
- data_read_ev  in  1  one data read this cycle
- data_write_ev  in  1  one data write this cycle
- data_hit_ev  in  1  data cache hit this cycle
- data_miss_ev  in  1  data cache miss this cycle
- clear  in  1  zero live counters, level-sampled each cycle
- print_req  in  1  request snapshot and print, level-sampled in IDLE only
- busy  out  1  high while FSM not IDLE
- print  out  1  one-cycle strobe to the display block, snapshot outputs valid
- ins_reads, ins_hit, ins_miss  out  CNT_W each  snapshot counts, instruction side
- data_reads, data_writes, data_hit, data_miss  out  CNT_W each  snapshot counts, data side
- proto_err  out  1  sticky: hit and miss strobed together on the same side

## Operation
- Seven live counters, one per event input. Each increments by 1 on a cycle where its strobe is high. Counters are independent, so any combination may increment in the same cycle.
- Saturating: a counter at all-ones stays at all-ones and never wraps.
- clear=1: all live counters load 0 at that edge. Clear has priority over events in the same cycle, and those events are discarded. proto_err is also cleared. Snapshot outputs are not affected.
- proto_err sets when ins_hit_ev&ins_miss_ev or data_hit_ev&data_miss_ev. Both counters still increment. The flag holds until clear or reset.
- FSM states:
  - IDLE: if print_req, go to SNAP.
  - SNAP: snapshot registers load the live counter values, then go to PRINT.
  - PRINT: print=1, then go to IDLE.
- print_req outside IDLE is ignored, with no queueing. A requester must wait for busy=0.
- busy = (state != IDLE).
- Snapshot outputs change only on the SNAP edge, so they are stable across the print strobe and until the next SNAP.
- Live counting continues in every state.
- Reset, asynchronous, including mid-print: state=IDLE; all live counters, snapshots, print, busy and proto_err = 0.

## Timing
- print_req high in cycle N while in IDLE:
  - busy=1 in cycles N+1 and N+2.
  - SNAP occupies N+1.
  - Snapshot outputs update at the end of N+1 and hold the live values registered at the end of N, i.e. events through cycle N.
  - print=1 during N+2 only.
  - IDLE again in N+3, so a new print_req can be accepted in N+3.
- Events in cycle N+1 are counted live but are excluded from that snapshot.
- clear and print_req in the same cycle N: counters are 0 after N, so the snapshot is all zeros.
- clear during SNAP (cycle N+1): the snapshot still captures the pre-clear values, because it reads the registered live values.
- Latency from event strobe to live counter: 1 edge.
- No combinational path from inputs to outputs.

## Test plan
- Reset, then three cycles of ins_read_ev+ins_hit_ev, then print_req for one cycle -> print strobes exactly 2 cycles later with ins_reads=3, ins_hit=3 and all other outputs 0; busy high for 2 cycles.
- Data side: 5 data_write_ev and 2 data_miss_ev, with print_req in the same cycle as the last event -> snapshot data_writes=5, data_miss=2. Events driven during SNAP appear only in the next print.
- Saturation: force data_reads live value to 32'hFFFF_FFFE via events or a small CNT_W=4 build (14 events), then 3 more events -> snapshot shows all-ones and does not wrap.
- Clear priority: counts nonzero; clear+data_hit_ev in the same cycle, then print_req -> all snapshots 0. Prior snapshot outputs stay unchanged until this SNAP.
- print_req held continuously for 10 cycles -> print pulses at cycles 2, 5 and 8 (period 3); no request is accepted while busy.
- ins_hit_ev&ins_miss_ev together -> proto_err=1 and both counts increment. reset_n low during PRINT -> print drops immediately and all outputs read 0.
